// File: rtl/router_pkt_tx.sv
// Router input-port packet source: buffers payload, then sends header/payload/parity.
// Optional ROUTER_TX_PARITY_INJECT_EN adds inj_err to send an inverted parity byte.
module router_pkt_tx #(
   parameter int DEPTH    = 64,
   parameter int IDLE_GAP = 2,
   localparam int PTR_W   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             wr_en,
   input  logic [7:0]       wr_data,
   input  logic             start,
   input  logic [1:0]       dest,
   input  logic [5:0]       len,
   input  logic             busy,
`ifdef ROUTER_TX_PARITY_INJECT_EN
   input  logic             inj_err,
`endif
   output logic [7:0]       data_out,
   output logic             pkt_valid,
   output logic             tx_active,
   output logic             done,
   output logic             start_err,
   output logic             wr_ovf,
   output logic [PTR_W:0]   count
);

   localparam int GAP_W = $clog2(IDLE_GAP + 1);
   localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);
   localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'(IDLE_GAP - 1);

   typedef enum logic [2:0] {IDLE, HDR, PLD, PAR, GAP} state_t;

   state_t             state, state_nx;
   logic [7:0]         mem [DEPTH];
   logic [PTR_W-1:0]   wr_ptr, rd_ptr;
   logic [5:0]         rem;
   logic [7:0]         parity;
   logic [7:0]         par_out;
   logic [GAP_W-1:0]   gap;
   logic               start_ok, start_bad, rd_en, wr_ok;

`ifdef ROUTER_TX_PARITY_INJECT_EN
   logic inj_q;
   assign par_out = inj_q ? ~parity : parity;
`else
   assign par_out = parity;
`endif

   always_ff @(posedge clk) begin
      if (!resetn) state <= IDLE;
      else         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:     if (start_ok) state_nx = HDR;
         HDR, PLD: if (!busy) state_nx = (rem != '0) ? PLD : PAR;
         PAR:      if (!busy) state_nx = GAP;
         GAP:      if (gap == '0) state_nx = IDLE;
         default:  state_nx = IDLE;
      endcase
   end

   // Launch legality and buffer-side strobes for this cycle.
   always_comb begin
      start_ok  = 1'b0;
      start_bad = 1'b0;
      if (state == IDLE && start) begin
         if (dest != 2'd3 && len != '0 && (PTR_W+1)'(len) <= count)
            start_ok = 1'b1;
         else
            start_bad = 1'b1;
      end
      rd_en = (state == HDR || state == PLD) && !busy && rem != '0;
      wr_ok = wr_en && count != FULL;
   end

   always_ff @(posedge clk) begin
      if (wr_ok) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         data_out  <= '0;
         pkt_valid <= 1'b0;
         tx_active <= 1'b0;
         done      <= 1'b0;
         start_err <= 1'b0;
         wr_ovf    <= 1'b0;
         count     <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         rem       <= '0;
         parity    <= '0;
         gap       <= '0;
`ifdef ROUTER_TX_PARITY_INJECT_EN
         inj_q     <= 1'b0;
`endif
      end else begin
         done      <= 1'b0;
         start_err <= start_bad;
         wr_ovf    <= wr_en && count == FULL;
         if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;
         unique case ({wr_ok, rd_en})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
         unique case (state)
            IDLE: if (start_ok) begin
               data_out  <= {len, dest};
               pkt_valid <= 1'b1;
               parity    <= {len, dest};
               rem       <= len;
               tx_active <= 1'b1;
`ifdef ROUTER_TX_PARITY_INJECT_EN
               inj_q     <= inj_err;
`endif
            end
            HDR, PLD: if (!busy) begin
               if (rem != '0) begin
                  data_out <= mem[rd_ptr];
                  parity   <= parity ^ mem[rd_ptr];
                  rem      <= rem - 1'b1;
               end else begin
                  data_out  <= par_out;
                  pkt_valid <= 1'b0;
               end
            end
            PAR: if (!busy) begin
               data_out <= '0;
               done     <= 1'b1;
               gap      <= GAP_INIT;
            end
            GAP: begin
               if (gap == '0) tx_active <= 1'b0;
               else           gap <= gap - 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Bench for router_pkt_tx: beat-queue reference model checked every cycle,
// plus directed packets with literal expectations.
module tb_router_pkt_tx;

   localparam int DEPTH    = 64;
   localparam int IDLE_GAP = 2;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       wr_en = 1'b0;
   logic [7:0] wr_data = '0;
   logic       start = 1'b0;
   logic [1:0] dest = '0;
   logic [5:0] len = '0;
   logic       busy = 1'b0;
`ifdef ROUTER_TX_PARITY_INJECT_EN
   logic       inj_err = 1'b0;
`endif
   logic [7:0] data_out;
   logic       pkt_valid, tx_active, done, start_err, wr_ovf;
   logic [6:0] count;

   int checks = 0;
   int failures = 0;
   int ovf_seen = 0;
   bit armed = 1'b0;

   router_pkt_tx #(.DEPTH(DEPTH), .IDLE_GAP(IDLE_GAP)) dut (
      .clk(clk),
      .resetn(resetn),
      .wr_en(wr_en),
      .wr_data(wr_data),
      .start(start),
      .dest(dest),
      .len(len),
      .busy(busy),
`ifdef ROUTER_TX_PARITY_INJECT_EN
      .inj_err(inj_err),
`endif
      .data_out(data_out),
      .pkt_valid(pkt_valid),
      .tx_active(tx_active),
      .done(done),
      .start_err(start_err),
      .wr_ovf(wr_ovf),
      .count(count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         if (failures < 40)
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: buffer as a byte queue, packet as a list of beats.
   logic [7:0] bq[$];
   logic [7:0] bt[$];
   int         m_phase = 0;
   int         bi = 0, blen = 0, gapleft = 0;
   logic [7:0] e_data = '0;
   logic       e_valid = 0, e_act = 0, e_done = 0, e_serr = 0, e_ovf = 0;
   int         e_count = 0;

   always @(posedge clk) begin
      int sz;
      bit pop;
      logic [7:0] p;
      sz  = bq.size();
      pop = 1'b0;
      if (!resetn) begin
         bq.delete();
         m_phase = 0;
         e_data = '0; e_valid = 0; e_act = 0;
         e_done = 0; e_serr = 0; e_ovf = 0; e_count = 0;
      end else begin
         e_done = 0; e_serr = 0; e_ovf = 0;
         case (m_phase)
            0: if (start) begin
               if (dest != 2'd3 && len != 0 && int'(len) <= sz) begin
                  bt.delete();
                  bt.push_back({len, dest});
                  for (int i = 0; i < int'(len); i++) bt.push_back(bq[i]);
                  p = '0;
                  foreach (bt[i]) p ^= bt[i];
`ifdef ROUTER_TX_PARITY_INJECT_EN
                  if (inj_err) p = ~p;
`endif
                  bt.push_back(p);
                  blen = int'(len);
                  bi = 0;
                  e_data = bt[0]; e_valid = 1; e_act = 1;
                  m_phase = 1;
               end else e_serr = 1;
            end
            1: if (!busy) begin
               if (bi < blen) pop = 1;
               bi++;
               if (bi == blen + 2) begin
                  e_data = '0; e_done = 1;
                  gapleft = IDLE_GAP;
                  m_phase = 2;
               end else begin
                  e_data = bt[bi];
                  e_valid = (bi <= blen);
               end
            end
            default: begin
               gapleft--;
               if (gapleft == 0) begin m_phase = 0; e_act = 0; end
            end
         endcase
         if (pop) void'(bq.pop_front());
         if (wr_en) begin
            if (sz == DEPTH) e_ovf = 1;
            else bq.push_back(wr_data);
         end
         e_count = bq.size();
      end
   end

   always @(negedge clk) begin
      if (armed) begin
         chk("data_out", data_out, e_data);
         chk("pkt_valid", pkt_valid, e_valid);
         chk("tx_active", tx_active, e_act);
         chk("done", done, e_done);
         chk("start_err", start_err, e_serr);
         chk("wr_ovf", wr_ovf, e_ovf);
         chk("count", count, e_count);
         if (wr_ovf === 1'b1) ovf_seen++;
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic wr(input logic [7:0] b);
      wr_en = 1'b1;
      wr_data = b;
      tick();
      wr_en = 1'b0;
   endtask

   task automatic launch(input logic [1:0] d, input logic [5:0] l,
                         input bit inj);
      start = 1'b1;
      dest = d;
      len = l;
`ifdef ROUTER_TX_PARITY_INJECT_EN
      inj_err = inj;
`else
      if (inj) $display("note: inj ignored in default build");
`endif
      tick();
      start = 1'b0;
`ifdef ROUTER_TX_PARITY_INJECT_EN
      inj_err = 1'b0;
`endif
   endtask

   task automatic wait_idle(input string nm);
      int n = 0;
      while ((tx_active !== 1'b0 || m_phase != 0) && n < 500) begin
         tick();
         n++;
      end
      chk(nm, n < 500, 1);
      tick();
   endtask

   initial begin
      int ovf0, par_i, hdr_i, rises, gapc;
      logic pv [20];

      tick(2);
      chk("rst_data", data_out, 0);
      chk("rst_valid", pkt_valid, 0);
      chk("rst_count", count, 0);
      chk("rst_active", tx_active, 0);
      armed = 1'b1;
      resetn = 1'b1;
      tick();

      // Basic packet
      wr(8'h11); wr(8'h22); wr(8'h33);
      chk("t1_count", count, 3);
      launch(2'd1, 6'd3, 0);
      chk("t1_hdr", {pkt_valid, data_out}, 9'h10D); tick();
      chk("t1_b1", {pkt_valid, data_out}, 9'h111); tick();
      chk("t1_b2", {pkt_valid, data_out}, 9'h122); tick();
      chk("t1_b3", {pkt_valid, data_out}, 9'h133); tick();
      chk("t1_par", {pkt_valid, data_out}, 9'h00D); tick();
      chk("t1_done", {done, data_out}, 9'h100);
      wait_idle("t1_idle");

      // Busy stall on byte 0x22
      wr(8'h11); wr(8'h22); wr(8'h33);
      launch(2'd1, 6'd3, 0);
      tick(2);
      chk("t2_hold0", data_out, 8'h22); busy = 1'b1; tick();
      chk("t2_hold1", data_out, 8'h22); tick();
      chk("t2_hold2", data_out, 8'h22); tick();
      chk("t2_hold3", data_out, 8'h22); busy = 1'b0; tick();
      chk("t2_next", data_out, 8'h33); tick();
      chk("t2_par", {pkt_valid, data_out}, 9'h00D);
      wait_idle("t2_idle");

      // Rejected starts
      for (int i = 0; i < 4; i++) wr(8'(8'hA0 + i));
      launch(2'd3, 6'd1, 0);
      chk("t3_err_dest", {start_err, pkt_valid}, 2'b10);
      launch(2'd0, 6'd0, 0);
      chk("t3_err_len0", {start_err, pkt_valid}, 2'b10);
      launch(2'd0, 6'd5, 0);
      chk("t3_err_short", {start_err, pkt_valid}, 2'b10);
      chk("t3_count", count, 4);
      launch(2'd2, 6'd4, 0);
      chk("t3_hdr", data_out, 8'h12);
      wait_idle("t3_idle");
      chk("t3_drained", count, 0);

      // Overflow and pointer wrap
      ovf0 = ovf_seen;
      for (int i = 0; i < 65; i++) wr(8'(i * 7 + 3));
      tick();
      chk("t4_full", count, 64);
      chk("t4_ovf", ovf_seen - ovf0, 1);
      launch(2'd1, 6'd32, 0);
      wait_idle("t4_idle1");
      chk("t4_half", count, 32);
      launch(2'd2, 6'd32, 0);
      wait_idle("t4_idle2");
      chk("t4_empty", count, 0);

      // Back-to-back with start held
      for (int i = 0; i < 4; i++) wr(8'(8'h5C ^ i));
      dest = 2'd0;
      len = 6'd2;
      start = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         pv[i] = pkt_valid;
      end
      start = 1'b0;
      par_i = -1; hdr_i = -1; rises = 0;
      for (int i = 1; i < 20; i++) begin
         if (pv[i] && !pv[i-1]) begin
            rises++;
            if (par_i >= 0 && hdr_i < 0) hdr_i = i;
         end
         if (!pv[i] && pv[i-1] && par_i < 0) par_i = i;
      end
      if (pv[0]) rises++;
      gapc = (par_i >= 0 && hdr_i > par_i) ? hdr_i - par_i - 1 : -1;
      chk("t5_pkts", rises, 2);
      chk("t5_gap_min", gapc >= IDLE_GAP, 1);
      wait_idle("t5_idle");

      // Reset mid-payload
      for (int i = 0; i < 5; i++) wr(8'(8'h40 + i));
      launch(2'd1, 6'd5, 0);
      tick(2);
      resetn = 1'b0;
      tick();
      chk("t6_rst", {tx_active, pkt_valid, data_out}, 10'h000);
      chk("t6_rst_count", count, 0);
      resetn = 1'b1;
      wr(8'h77); wr(8'h88);
      launch(2'd2, 6'd2, 0);
      chk("t6_hdr", data_out, 8'h0A);
      wait_idle("t6_idle");

`ifdef ROUTER_TX_PARITY_INJECT_EN
      wr(8'hA5); wr(8'h5A);
      launch(2'd1, 6'd2, 1);
      chk("t7_hdr", data_out, 8'h09);
      tick(3);
      chk("t7_badpar", {pkt_valid, data_out}, 9'h009);
      wait_idle("t7_idle");
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      failures++;
      $display("FAIL watchdog actual=timeout expected=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
